// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter that sequences one memory transaction per grant
// over a valid/ready port; a watchdog aborts transactions whose ready never arrives.
module mem_rr_arbiter #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_wr_rd,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*WIDTH-1:0]      req_wdata,
  output logic [1:0]              req_done,
  output logic [1:0]              req_err,
  output logic [WIDTH-1:0]        rsp_rdata,
  output logic                    mem_valid,
  output logic                    mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic                    mem_ready,
  input  logic [WIDTH-1:0]        mem_rdata
);

  localparam int unsigned        TCNT_W    = $clog2(TIMEOUT);
  localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                gnt_q, gnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

  logic                  mem_valid_d, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_d, rsp_rdata_d;
  logic [1:0]            req_done_d, req_err_d;

  // On a tie the requester that did not win last time is served.
  logic win_c;
  assign win_c = (req_valid == 2'b11) ? ~last_gnt_q : req_valid[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      tcnt_q     <= '0;
      mem_valid  <= 1'b0;
      mem_wr_rd  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_rdata  <= '0;
      req_done   <= '0;
      req_err    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      tcnt_q     <= tcnt_d;
      mem_valid  <= mem_valid_d;
      mem_wr_rd  <= mem_wr_rd_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      rsp_rdata  <= rsp_rdata_d;
      req_done   <= req_done_d;
      req_err    <= req_err_d;
    end
  end

  // Grant, hold the command while BUSY, and retire it on ready or watchdog expiry.
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    tcnt_d      = tcnt_q;
    mem_valid_d = mem_valid;
    mem_wr_rd_d = mem_wr_rd;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    rsp_rdata_d = rsp_rdata;
    req_done_d  = '0;
    req_err_d   = '0;

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          gnt_d       = win_c;
          mem_valid_d = 1'b1;
          mem_wr_rd_d = win_c ? req_wr_rd[1] : req_wr_rd[0];
          mem_addr_d  = win_c ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          mem_wdata_d = win_c ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
          tcnt_d      = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_valid_d       = 1'b0;
          req_done_d[gnt_q] = 1'b1;
          if (!mem_wr_rd) begin
            rsp_rdata_d = mem_rdata;
          end
          last_gnt_d = gnt_q;
          state_d    = IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          mem_valid_d       = 1'b0;
          req_done_d[gnt_q] = 1'b1;
          req_err_d[gnt_q]  = 1'b1;
          last_gnt_d        = gnt_q;
          state_d           = IDLE;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus randomized traffic, checked by a
// transaction-level reference model feeding a scoreboard that a separate monitor drains.
module tb_mem_rr_arbiter;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned AW      = 6;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]        req_valid, req_wr_rd, req_done, req_err;
  logic [2*AW-1:0]   req_addr;
  logic [2*WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0]  rsp_rdata, mem_wdata, mem_rdata;
  logic              mem_valid, mem_wr_rd, mem_ready;
  logic [AW-1:0]     mem_addr;

  mem_rr_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid(req_valid), .req_wr_rd(req_wr_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic wr; logic [AW-1:0] addr; logic [WIDTH-1:0] wdata; } cmd_t;
  typedef struct { int unsigned cyc; logic [1:0] done; logic [1:0] err; logic [WIDTH-1:0] rdata; } done_t;
  cmd_t  cmd_q[$];
  done_t done_q[$];
  logic  exp_mv;
  int    resp_mode;  // 0: random latency, 99: never ready, else ready on that BUSY cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got nothing expected an event (cycle %0d)", name, cyc);
  endtask

  // Memory responder: counts cycles of mem_valid and answers on the chosen one.
  initial begin : responder
    logic [WIDTH-1:0] mem_arr [DEPTH];
    int bcnt;
    int target;
    int k;
    for (int i = 0; i < int'(DEPTH); i++) mem_arr[i] = WIDTH'($urandom);
    mem_ready = 1'b0;
    mem_rdata = '0;
    bcnt = 0;
    target = 0;
    forever begin
      @(negedge clk);
      if (rst || !mem_valid) begin
        bcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = WIDTH'($urandom);
      end else begin
        if (bcnt == 0) begin
          if (resp_mode == 99) target = 0;
          else if (resp_mode != 0) target = resp_mode;
          else begin
            k = int'($urandom_range(0, 15));
            target = (k == 0) ? 0 : (k == 1) ? 16 : int'($urandom_range(1, 4));
          end
        end
        bcnt++;
        if (target != 0 && bcnt == target) begin
          mem_ready = 1'b1;
          if (mem_wr_rd) begin
            mem_arr[mem_addr] = mem_wdata;
            mem_rdata = WIDTH'($urandom);
          end else begin
            mem_rdata = mem_arr[mem_addr];
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = WIDTH'($urandom);
        end
      end
    end
  end

  // Reference model: one transaction at a time, alternating winners on ties.
  initial begin : model
    bit busy;
    bit w;
    bit last;
    int cnt;
    int wi;
    logic [WIDTH-1:0] rd;
    cmd_t c, cur;
    done_t d;
    busy = 0; w = 0; wi = 0; last = 1; cnt = 0; rd = '0; exp_mv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        busy = 0; last = 1; cnt = 0; rd = '0; exp_mv = 1'b0;
        cmd_q.delete();
        done_q.delete();
      end else if (!busy) begin
        if (req_valid != 2'b00) begin
          w  = (req_valid == 2'b11) ? !last : req_valid[1];
          wi = int'(w);
          c.cyc = cyc;
          c.wr = req_wr_rd[wi];
          c.addr = req_addr[wi*AW +: AW];
          c.wdata = req_wdata[wi*WIDTH +: WIDTH];
          cmd_q.push_back(c);
          cur = c;
          busy = 1; cnt = 1; exp_mv = 1'b1;
        end
      end else if (mem_ready || cnt == int'(TIMEOUT)) begin
        d.cyc = cyc;
        d.done = 2'b01 << wi;
        d.err = mem_ready ? 2'b00 : (2'b01 << wi);
        if (mem_ready && !cur.wr) rd = mem_rdata;
        d.rdata = rd;
        done_q.push_back(d);
        busy = 0; last = w; exp_mv = 1'b0;
      end else begin
        cnt++;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin : monitor
    logic pmv;
    cmd_t c, cur;
    done_t d;
    pmv = 1'b0;
    cur.cyc = 0; cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        pmv = 1'b0;
        check("reset_ctl", {mem_valid, req_done, req_err, rsp_rdata}, 32'h0);
        check("reset_cmd", {mem_wr_rd, mem_addr, mem_wdata}, 32'h0);
        continue;
      end
      check("mem_valid", mem_valid, exp_mv);
      if (mem_valid && !pmv) begin
        if (cmd_q.size() == 0) fail("unexpected_cmd");
        else begin
          c = cmd_q.pop_front();
          check("cmd_cycle", cyc, c.cyc);
          check("cmd_wr_rd", mem_wr_rd, c.wr);
          check("cmd_addr", mem_addr, c.addr);
          check("cmd_wdata", mem_wdata, c.wdata);
          cur = c;
        end
      end else if (mem_valid) begin
        check("cmd_stable", {mem_wr_rd, mem_addr, mem_wdata}, {cur.wr, cur.addr, cur.wdata});
      end
      if (req_done != 2'b00 || req_err != 2'b00) begin
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("req_done", req_done, d.done);
          check("req_err", req_err, d.err);
          check("rsp_rdata", rsp_rdata, d.rdata);
        end
      end
      pmv = mem_valid;
    end
  end

  task automatic set_req(input int r, input logic v, input logic wr,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] dat);
    req_valid[r] = v;
    req_wr_rd[r] = wr;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*WIDTH +: WIDTH] = dat;
  endtask

  // Counts clock edges until any req_done pulse, sampling after each edge.
  task automatic wait_done(input int max, output int n, output logic [1:0] seen);
    n = 0;
    seen = 2'b00;
    while (n < max) begin
      @(posedge clk); #3;
      n++;
      if (req_done != 2'b00) begin
        seen = req_done;
        break;
      end
    end
    if (seen == 2'b00) fail("done_wait_budget");
  endtask

  initial begin : main
    int n;
    logic [1:0] seen;
    int remaining[2];
    int waitc[2];
    bit act[2];
    int guard;
    rst = 1'b1;
    req_valid = '0; req_wr_rd = '0; req_addr = '0; req_wdata = '0;
    resp_mode = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single write, minimum latency.
    @(negedge clk); set_req(0, 1'b1, 1'b1, 6'h05, 16'hA5A5);
    @(posedge clk); #3;
    check("t1_cmd", {mem_valid, mem_wr_rd, mem_addr, mem_wdata}, {1'b1, 1'b1, 6'h05, 16'hA5A5});
    wait_done(20, n, seen);
    check("t1_latency", n + 1, 2);
    check("t1_done", {seen, req_err}, {2'b01, 2'b00});
    @(negedge clk); set_req(0, 1'b0, 1'b0, '0, '0);

    // Read back from the other requester.
    @(negedge clk); set_req(1, 1'b1, 1'b0, 6'h05, 16'h0000);
    @(posedge clk); #3;
    check("t2_cmd_rd", {mem_valid, mem_wr_rd}, {1'b1, 1'b0});
    wait_done(20, n, seen);
    check("t2_done", {seen, req_err}, {2'b10, 2'b00});
    check("t2_rdata", rsp_rdata, 16'hA5A5);
    @(negedge clk); set_req(1, 1'b0, 1'b0, '0, '0);

    // Contention after reset: 0,1,0,1 then the remaining requester.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 6'h10, 16'h1000);
    set_req(1, 1'b1, 1'b1, 6'h20, 16'h2000);
    for (int i = 0; i < 4; i++) begin
      wait_done(20, n, seen);
      check("t3_order", seen, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      if (i < 3) set_req(seen[1] ? 1 : 0, 1'b1, 1'b1, AW'(6'h11 + i), WIDTH'(16'h3000 + i));
      else set_req(1, 1'b0, 1'b0, '0, '0);
    end
    wait_done(20, n, seen);
    check("t3_tail", seen, 2'b01);
    @(negedge clk); set_req(0, 1'b0, 1'b0, '0, '0);

    // Watchdog abort, then a normal read.
    resp_mode = 99;
    @(negedge clk); set_req(0, 1'b1, 1'b0, 6'h03, 16'h0);
    wait_done(40, n, seen);
    check("t4_latency", n, 17);
    check("t4_done", {seen, req_err}, {2'b01, 2'b01});
    check("t4_rdata_kept", rsp_rdata, 16'h0000);
    @(negedge clk); set_req(0, 1'b0, 1'b0, '0, '0);
    resp_mode = 1;
    @(negedge clk); set_req(1, 1'b1, 1'b0, 6'h05, 16'h0);
    wait_done(20, n, seen);
    check("t4_next_latency", n, 2);
    check("t4_next_done", {seen, req_err}, {2'b10, 2'b00});
    check("t4_next_rdata", rsp_rdata, 16'hA5A5);
    @(negedge clk); set_req(1, 1'b0, 1'b0, '0, '0);

    // Ready arriving on the last allowed BUSY cycle is a success.
    resp_mode = 16;
    @(negedge clk); set_req(0, 1'b1, 1'b1, 6'h09, 16'h1234);
    wait_done(40, n, seen);
    check("t5_latency", n, 17);
    check("t5_done", {seen, req_err}, {2'b01, 2'b00});
    @(negedge clk); set_req(0, 1'b0, 1'b0, '0, '0);

    // Reset while BUSY drops everything asynchronously; tie then goes to requester 0.
    resp_mode = 99;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 6'h01, 16'h0);
    set_req(1, 1'b1, 1'b0, 6'h02, 16'h0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("t6_async", {mem_valid, req_done, req_err}, 5'b0);
    @(negedge clk); resp_mode = 1;
    @(negedge clk); rst = 1'b0;
    wait_done(20, n, seen);
    check("t6_first", {seen, req_err}, {2'b01, 2'b00});
    @(negedge clk); set_req(0, 1'b0, 1'b0, '0, '0);
    wait_done(20, n, seen);
    check("t6_second", seen, 2'b10);
    @(negedge clk); set_req(1, 1'b0, 1'b0, '0, '0);

    // Randomized traffic against the model.
    resp_mode = 0;
    remaining[0] = 60; remaining[1] = 60;
    waitc[0] = 0; waitc[1] = 0;
    act[0] = 0; act[1] = 0;
    guard = 0;
    while ((remaining[0] + remaining[1]) > 0 || act[0] || act[1]) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        fail("random_phase_budget");
        break;
      end
      for (int r = 0; r < 2; r++) begin
        if (act[r] && req_done[r]) begin
          act[r] = 0;
          set_req(r, 1'b0, 1'b0, '0, '0);
          waitc[r] = int'($urandom_range(0, 3));
        end
        if (!act[r] && remaining[r] > 0) begin
          if (waitc[r] == 0) begin
            set_req(r, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), WIDTH'($urandom));
            act[r] = 1;
            remaining[r]--;
          end else begin
            waitc[r]--;
          end
        end
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", cmd_q.size() + done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
